// File: rtl/draw_pkg.sv
// Shared types and constants for the arc-set drawer and its midpoint-circle engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_pkg;

    localparam int X_W           = 8;    // screen x coordinate width
    localparam int Y_W           = 7;    // screen y coordinate width
    localparam int COORD_W       = 10;   // signed working width for point coordinates
    localparam int COL_W         = 3;    // pixel colour width
    localparam int R_W_DEF       = 8;    // radius width stored in a descriptor slot
    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_SCREEN_H  = 120;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEXT_ARC,
        ST_OCT,
        ST_STEP,
        ST_DONE
    } draw_state_t;

    // One arc: centre, radius and inclusive clip window.
    typedef struct packed {
        logic               en;
        logic [X_W-1:0]     cx;
        logic [Y_W-1:0]     cy;
        logic [R_W_DEF-1:0] r;
        logic [X_W-1:0]     xlo;
        logic [X_W-1:0]     xhi;
        logic [Y_W-1:0]     ylo;
        logic [Y_W-1:0]     yhi;
    } arc_desc_t;

endpackage

// File: rtl/circle_octant_engine.sv
// Midpoint-circle walker: holds ox/oy/crit and an octant counter, presents one signed point.
// Latency: point valid the cycle after load; one octant per advance, one oy step per step.
// Backpressure: point is held while neither advance nor step is asserted.
module circle_octant_engine
    import draw_pkg::*;
#(
    parameter int R_W = R_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      advance,
    input  logic                      step,
    input  logic [X_W-1:0]            cx,
    input  logic [Y_W-1:0]            cy,
    input  logic [R_W-1:0]            r,
    output logic signed [COORD_W-1:0] px,
    output logic signed [COORD_W-1:0] py,
    output logic                      last,
    output logic                      more
);

    localparam int CW = R_W + 3;

    logic signed [COORD_W-1:0] cx_q, cy_q, ox, oy;
    logic signed [CW-1:0]      crit;
    logic [2:0]                oct;

    logic signed [COORD_W-1:0] oy_n, ox_dec, ox_n;
    logic signed [CW-1:0]      oy_c, ox_c, crit_n;
    logic                      crit_le0;

    // Next midpoint iteration: oy always advances, ox steps in when the decision goes positive.
    always_comb begin
        oy_n     = oy + COORD_W'(1);
        ox_dec   = ox - COORD_W'(1);
        oy_c     = CW'(oy_n);
        ox_c     = CW'(ox_dec);
        crit_le0 = crit[CW-1] || (crit == '0);
        if (crit_le0) begin
            ox_n   = ox;
            crit_n = crit + oy_c + oy_c + CW'(1);
        end else begin
            ox_n   = ox_dec;
            crit_n = crit + ((oy_c - ox_c) <<< 1) + CW'(1);
        end
        more = (oy_n <= ox_n);
    end

    // Engine state: loaded per arc, octant counter per point, ox/oy/crit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
            ox   <= '0;
            oy   <= '0;
            crit <= '0;
            oct  <= '0;
        end else if (load) begin
            cx_q <= COORD_W'(cx);
            cy_q <= COORD_W'(cy);
            ox   <= COORD_W'(r);
            oy   <= '0;
            crit <= CW'(1) - CW'(r);
            oct  <= '0;
        end else begin
            if (advance) oct <= oct + 3'd1;
            if (step) begin
                oy   <= oy_n;
                ox   <= ox_n;
                crit <= crit_n;
            end
        end
    end

    // Octant point selection in the fixed emission order.
    always_comb begin
        px = cx_q + ox;
        py = cy_q + oy;
        case (oct)
            3'd0: begin px = cx_q + ox; py = cy_q + oy; end
            3'd1: begin px = cx_q + oy; py = cy_q + ox; end
            3'd2: begin px = cx_q - oy; py = cy_q + ox; end
            3'd3: begin px = cx_q - ox; py = cy_q + oy; end
            3'd4: begin px = cx_q - ox; py = cy_q - oy; end
            3'd5: begin px = cx_q - oy; py = cy_q - ox; end
            3'd6: begin px = cx_q + oy; py = cy_q - ox; end
            default: begin px = cx_q + ox; py = cy_q - oy; end
        endcase
    end

    assign last = (oct == 3'd7);

endmodule

// File: rtl/arc_set_drawer.sv
// Draws up to N_ARCS clipped circle arcs from a host-written descriptor table onto the VGA adapter.
// Latency: 9 cycles per oy iteration at full rate; done two cycles after start when n_arcs=0.
// Backpressure: a qualifying point holds on vga_x/vga_y/vga_plot until vga_ready; rejects cost one cycle.
module arc_set_drawer
    import draw_pkg::*;
#(
    parameter int N_ARCS   = 4,
    parameter int IDX_W    = (N_ARCS > 1) ? $clog2(N_ARCS) : 1,
    parameter int R_W      = R_W_DEF,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               done,
    input  logic [IDX_W:0]     n_arcs,
    input  logic [COL_W-1:0]   colour,
    input  logic               desc_we,
    input  logic [IDX_W-1:0]   desc_idx,
    input  logic               desc_en,
    input  logic [X_W-1:0]     desc_cx,
    input  logic [Y_W-1:0]     desc_cy,
    input  logic [R_W-1:0]     desc_r,
    input  logic [X_W-1:0]     desc_xlo,
    input  logic [X_W-1:0]     desc_xhi,
    input  logic [Y_W-1:0]     desc_ylo,
    input  logic [Y_W-1:0]     desc_yhi,
    input  logic               vga_ready,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COL_W-1:0]   vga_colour,
    output logic               vga_plot
);

    localparam int AW = IDX_W + 1;

    draw_state_t state, state_n;
    arc_desc_t   desc_tab [N_ARCS];
    arc_desc_t   sel_desc;

    logic [AW-1:0]    arc, n_lat, n_clamp;
    logic [COL_W-1:0] col_lat;
    logic signed [COORD_W-1:0] xlo_s, xhi_s, ylo_s, yhi_s, sw_s, sh_s;
    logic signed [COORD_W-1:0] px, py;
    logic eng_load, eng_adv, eng_step, arc_inc;
    logic oct_last, more, in_win, on_scr, plot;

    circle_octant_engine #(.R_W(R_W)) u_engine (
        .clk     (clk),
        .rst     (rst),
        .load    (eng_load),
        .advance (eng_adv),
        .step    (eng_step),
        .cx      (sel_desc.cx),
        .cy      (sel_desc.cy),
        .r       (R_W'(sel_desc.r)),
        .px      (px),
        .py      (py),
        .last    (oct_last),
        .more    (more)
    );

    // Descriptor table: host writes land only while idle; reset disables every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ARCS; i++) desc_tab[i].en <= 1'b0;
        end else if (desc_we && state == ST_IDLE && ({1'b0, desc_idx} < AW'(N_ARCS))) begin
            desc_tab[desc_idx] <= '{en: desc_en, cx: desc_cx, cy: desc_cy, r: R_W_DEF'(desc_r),
                                    xlo: desc_xlo, xhi: desc_xhi, ylo: desc_ylo, yhi: desc_yhi};
        end
    end

    // Slot lookup, arc-count clamp and point qualification against window and screen.
    always_comb begin
        sel_desc = desc_tab[arc[IDX_W-1:0]];
        n_clamp  = (n_arcs > AW'(N_ARCS)) ? AW'(N_ARCS) : n_arcs;
        sw_s     = COORD_W'(SCREEN_W);
        sh_s     = COORD_W'(SCREEN_H);
        in_win   = (px >= xlo_s) && (px <= xhi_s) && (py >= ylo_s) && (py <= yhi_s);
        on_scr   = !px[COORD_W-1] && (px < sw_s) && !py[COORD_W-1] && (py < sh_s);
        plot     = (state == ST_OCT) && in_win && on_scr;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state and engine/sequencer controls.
    always_comb begin
        state_n  = state;
        eng_load = 1'b0;
        eng_adv  = 1'b0;
        eng_step = 1'b0;
        arc_inc  = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_n = ST_NEXT_ARC;
            ST_NEXT_ARC: begin
                if (arc == n_lat) begin
                    state_n = ST_DONE;
                end else if (!sel_desc.en) begin
                    arc_inc = 1'b1;
                end else begin
                    eng_load = 1'b1;
                    state_n  = ST_OCT;
                end
            end
            ST_OCT: begin
                if (!plot || vga_ready) begin
                    eng_adv = 1'b1;
                    if (oct_last) state_n = ST_STEP;
                end
            end
            ST_STEP: begin
                eng_step = 1'b1;
                if (more) begin
                    state_n = ST_OCT;
                end else begin
                    arc_inc = 1'b1;
                    state_n = ST_NEXT_ARC;
                end
            end
            ST_DONE: if (!start) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Transaction context: arc count and colour at start, clip window per arc.
    always_ff @(posedge clk) begin
        if (rst) begin
            arc     <= '0;
            n_lat   <= '0;
            col_lat <= '0;
            xlo_s   <= '0;
            xhi_s   <= '0;
            ylo_s   <= '0;
            yhi_s   <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                n_lat   <= n_clamp;
                col_lat <= colour;
                arc     <= '0;
            end
            if (arc_inc) arc <= arc + AW'(1);
            if (eng_load) begin
                xlo_s <= COORD_W'(sel_desc.xlo);
                xhi_s <= COORD_W'(sel_desc.xhi);
                ylo_s <= COORD_W'(sel_desc.ylo);
                yhi_s <= COORD_W'(sel_desc.yhi);
            end
        end
    end

    assign done       = (state == ST_DONE);
    assign vga_plot   = plot;
    assign vga_x      = px[X_W-1:0];
    assign vga_y      = py[Y_W-1:0];
    assign vga_colour = plot ? col_lat : '0;

endmodule
